// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions used by the instruction fetch stage.
package riscv_pkg;

   localparam int XLEN = 64;

   // addi x0, x0, 0
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_RESET = 2'd0,
      IF_RUN   = 2'd1,
      IF_HALT  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } ifid_entry_t;

   // Empty IF/ID slot: decode sees a NOP with valid low.
   function automatic ifid_entry_t ifid_bubble();
      ifid_entry_t e;
      e.valid = 1'b0;
      e.pc    = '0;
      e.instr = INSTR_NOP;
      return e;
   endfunction

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry hold register catching the fetch response that lands while
// decode is stalled. Flush wins over push.
module fetch_skid_buffer
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  ifid_entry_t din,
   output ifid_entry_t dout,
   output logic        valid
);

   ifid_entry_t entry_reg;
   logic        valid_reg;

   // Occupancy: cleared by reset or flush, set on push, cleared on pop.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_reg <= 1'b0;
      end else if (push) begin
         valid_reg <= 1'b1;
      end else if (pop) begin
         valid_reg <= 1'b0;
      end
   end

   // Payload only matters while valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         entry_reg <= din;
      end
   end

   assign dout  = entry_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC generation, single-outstanding fetch to a 1-cycle synchronous
// instruction memory, stall skid and redirect/flush handling.
// Optional: define IF_FETCH_PERF_CNT_EN to build the delivered-instruction counter.
module instruction_fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_en,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [31:0]     id_instruction,
   output logic            fetch_misaligned,
   output logic [XLEN-1:0] fetch_count
);

   fetch_state_t    state_reg, state_next;
   logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
   logic            inflight_reg;
   logic [XLEN-1:0] inflight_pc_reg;
   ifid_entry_t     ifid_reg, ifid_next;
   logic            ifid_load;
   logic            misaligned_reg, misaligned_next;

   logic            issue_en;
   logic [XLEN-1:0] issue_addr;
   ifid_entry_t     resp_entry;
   logic            skid_push, skid_pop, skid_flush, skid_valid;
   ifid_entry_t     skid_dout;

   // The memory answers exactly one cycle after issue, so a response killed by
   // a redirect always lands in the redirect cycle itself and is simply not
   // captured there; no separate drop flag has to survive past that cycle.
   assign resp_entry = '{valid: 1'b1, pc: inflight_pc_reg, instr: imem_rdata};

   fetch_skid_buffer u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (skid_push),
      .pop   (skid_pop),
      .flush (skid_flush),
      .din   (resp_entry),
      .dout  (skid_dout),
      .valid (skid_valid)
   );

   // Next-state, issue and IF/ID steering; redirect has top priority.
   always_comb begin
      state_next      = state_reg;
      fetch_pc_next   = fetch_pc_reg;
      misaligned_next = misaligned_reg;
      issue_en        = 1'b0;
      issue_addr      = fetch_pc_reg;
      ifid_load       = 1'b0;
      ifid_next       = ifid_bubble();
      skid_push       = 1'b0;
      skid_pop        = 1'b0;
      skid_flush      = 1'b0;

      if (redirect) begin
         skid_flush = 1'b1;
         ifid_load  = 1'b1;
         if (is_word_aligned(redirect_pc)) begin
            issue_en      = 1'b1;
            issue_addr    = redirect_pc;
            fetch_pc_next = redirect_pc + XLEN'(4);
            state_next    = IF_RUN;
         end else begin
            misaligned_next = 1'b1;
            state_next      = IF_HALT;
         end
      end else if (state_reg == IF_HALT) begin
         ifid_load = 1'b1;
      end else begin
         // First cycle out of reset always fetches RESET_PC.
         if (state_reg == IF_RESET) begin
            issue_en   = 1'b1;
            state_next = IF_RUN;
         end else begin
            issue_en = !stall;
         end
         if (issue_en) begin
            fetch_pc_next = fetch_pc_reg + XLEN'(4);
         end

         if (stall) begin
            skid_push = inflight_reg;
         end else if (skid_valid) begin
            ifid_load = 1'b1;
            ifid_next = skid_dout;
            skid_pop  = 1'b1;
         end else begin
            ifid_load = 1'b1;
            if (inflight_reg) begin
               ifid_next = resp_entry;
            end
         end
      end
   end

   assign imem_en   = issue_en && !rst;
   assign imem_addr = {issue_addr[XLEN-1:2], 2'b00};

   // Fetch state, PC, outstanding request and IF/ID boundary registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IF_RESET;
         fetch_pc_reg    <= RESET_PC;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
         ifid_reg        <= ifid_bubble();
         misaligned_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         fetch_pc_reg    <= fetch_pc_next;
         inflight_reg    <= issue_en;
         inflight_pc_reg <= imem_addr;
         misaligned_reg  <= misaligned_next;
         if (ifid_load) begin
            ifid_reg <= ifid_next;
         end
      end
   end

   assign id_valid         = ifid_reg.valid;
   assign id_pc            = ifid_reg.pc;
   assign id_instruction   = ifid_reg.instr;
   assign fetch_misaligned = misaligned_reg;

`ifdef IF_FETCH_PERF_CNT_EN
   logic [XLEN-1:0] fetch_count_reg;

   // Count every edge that hands a real instruction to decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count_reg <= '0;
      end else if (ifid_load && ifid_next.valid) begin
         fetch_count_reg <= fetch_count_reg + XLEN'(1);
      end
   end

   assign fetch_count = fetch_count_reg;
`else
   assign fetch_count = '0;
`endif

endmodule
